// File: rtl/morse_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : morse_decoder_if
// Purpose  : Character valid/ready channel from morse_decoder to its sink.
// Revision : 1.0
// ============================================================================
interface morse_decoder_if;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_out, output char_valid, input char_ready);
  modport slave  (input char_out, input char_valid, output char_ready);
endinterface
`default_nettype wire

// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_decoder
// Purpose  : Times a keyed on/off line into dots, dashes and gaps and decodes
//            each symbol to ASCII. Define MORSE_DEC_WORD_SPACE_EN to emit 0x20
//            on word gaps.
// Revision : 1.0
// ============================================================================
module morse_decoder #(
  parameter int UNIT_CYCLES = 3000000,
  parameter int CNT_WIDTH   = 24,
  parameter int MAX_ELEMS   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_in,
  morse_decoder_if.master sink,
  output logic            overflow,
  output logic            sym_err
);

  localparam int LEN_W = $clog2(MAX_ELEMS + 1);
  localparam int PAT_W = (MAX_ELEMS > 5) ? MAX_ELEMS : 5;
  localparam logic [CNT_WIDTH-1:0] CHAR_GAP = CNT_WIDTH'(2 * UNIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] WORD_GAP = CNT_WIDTH'(5 * UNIT_CYCLES);
  localparam logic [LEN_W-1:0]     LEN_MAX  = LEN_W'(MAX_ELEMS);

  typedef enum logic [1:0] {IDLE, MARK, GAP, WORD_WAIT} state_t;

  state_t                 state;
  logic                   sync1;
  logic                   key_s;
  logic                   key_d;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [MAX_ELEMS-1:0]   pattern;
  logic [LEN_W-1:0]       len;
  logic                   too_long;
  logic [7:0]             out_char;
  logic                   out_valid;

  logic [PAT_W-1:0]       pat_w;
  logic [4:0]             p5;
  logic [7:0]             len8;
  logic                   hi_zero;
  logic [7:0]             dec_char;
  logic                   emit;
  logic [7:0]             emit_char;
  logic                   emit_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      key_s <= 1'b0;
      key_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= key_in;
      key_s <= sync1;
      key_d <= key_s;
      if (key_s != key_d)
        cnt <= CNT_WIDTH'(1);
      else if (cnt != '1)
        cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // Pattern is right-aligned: the first element sits at bit len-1.
  assign pat_w   = PAT_W'(pattern);
  assign p5      = pat_w[4:0];
  assign hi_zero = ((pat_w >> 5) == '0);
  assign len8    = 8'(len);

  always_comb begin
    dec_char = 8'h3F;
    if (!too_long && hi_zero && len8 >= 8'd1 && len8 <= 8'd5) begin
      case ({len8[2:0], p5})
        {3'd2, 5'b00001}: dec_char = 8'h41;
        {3'd4, 5'b01000}: dec_char = 8'h42;
        {3'd4, 5'b01010}: dec_char = 8'h43;
        {3'd3, 5'b00100}: dec_char = 8'h44;
        {3'd1, 5'b00000}: dec_char = 8'h45;
        {3'd4, 5'b00010}: dec_char = 8'h46;
        {3'd3, 5'b00110}: dec_char = 8'h47;
        {3'd4, 5'b00000}: dec_char = 8'h48;
        {3'd2, 5'b00000}: dec_char = 8'h49;
        {3'd4, 5'b00111}: dec_char = 8'h4A;
        {3'd3, 5'b00101}: dec_char = 8'h4B;
        {3'd4, 5'b00100}: dec_char = 8'h4C;
        {3'd2, 5'b00011}: dec_char = 8'h4D;
        {3'd2, 5'b00010}: dec_char = 8'h4E;
        {3'd3, 5'b00111}: dec_char = 8'h4F;
        {3'd4, 5'b00110}: dec_char = 8'h50;
        {3'd4, 5'b01101}: dec_char = 8'h51;
        {3'd3, 5'b00010}: dec_char = 8'h52;
        {3'd3, 5'b00000}: dec_char = 8'h53;
        {3'd1, 5'b00001}: dec_char = 8'h54;
        {3'd3, 5'b00001}: dec_char = 8'h55;
        {3'd4, 5'b00001}: dec_char = 8'h56;
        {3'd3, 5'b00011}: dec_char = 8'h57;
        {3'd4, 5'b01001}: dec_char = 8'h58;
        {3'd4, 5'b01011}: dec_char = 8'h59;
        {3'd4, 5'b01100}: dec_char = 8'h5A;
        {3'd5, 5'b11111}: dec_char = 8'h30;
        {3'd5, 5'b01111}: dec_char = 8'h31;
        {3'd5, 5'b00111}: dec_char = 8'h32;
        {3'd5, 5'b00011}: dec_char = 8'h33;
        {3'd5, 5'b00001}: dec_char = 8'h34;
        {3'd5, 5'b00000}: dec_char = 8'h35;
        {3'd5, 5'b10000}: dec_char = 8'h36;
        {3'd5, 5'b11000}: dec_char = 8'h37;
        {3'd5, 5'b11100}: dec_char = 8'h38;
        {3'd5, 5'b11110}: dec_char = 8'h39;
        default:          dec_char = 8'h3F;
      endcase
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_char = dec_char;
    emit_err  = (dec_char == 8'h3F);
    if (state == GAP && cnt == CHAR_GAP) begin
      emit = 1'b1;
    end
`ifdef MORSE_DEC_WORD_SPACE_EN
    else if (state == WORD_WAIT && cnt == WORD_GAP) begin
      emit      = 1'b1;
      emit_char = 8'h20;
      emit_err  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pattern   <= '0;
      len       <= '0;
      too_long  <= 1'b0;
      out_char  <= 8'h00;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      sym_err   <= 1'b0;
    end else begin
      sym_err <= 1'b0;
      case (state)
        IDLE: begin
          if (key_s)
            state <= MARK;
        end
        MARK: begin
          // cnt still holds the full mark length on the first low cycle.
          if (!key_s) begin
            state <= GAP;
            if (len == LEN_MAX)
              too_long <= 1'b1;
            else begin
              pattern <= {pattern[MAX_ELEMS-2:0], (cnt >= CHAR_GAP)};
              len     <= len + LEN_W'(1);
            end
          end
        end
        GAP: begin
          if (cnt == CHAR_GAP) begin
            pattern  <= '0;
            len      <= '0;
            too_long <= 1'b0;
            state    <= key_s ? MARK : WORD_WAIT;
          end else if (key_s)
            state <= MARK;
        end
        WORD_WAIT: begin
          if (key_s)
            state <= MARK;
          else if (cnt == WORD_GAP)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (emit) begin
        if (!out_valid || sink.char_ready) begin
          out_char  <= emit_char;
          out_valid <= 1'b1;
          sym_err   <= emit_err;
        end else
          overflow <= 1'b1;
      end else if (out_valid && sink.char_ready)
        out_valid <= 1'b0;
    end
  end

  assign sink.char_out   = out_char;
  assign sink.char_valid = out_valid;

endmodule
`default_nettype wire

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Receive-side counterpart of the Morse encode path: timing-classifies a keyed on/off signal into dots, dashes and gaps, then decodes each completed symbol to 8-bit ASCII.
- Sits between the key/receiver input pin and the character sink (display, UART, or loopback checker), which consumes characters over a valid/ready interface.
- Contains a single-entry output register with a sticky overflow flag.

Parameters:
- UNIT_CYCLES, 3000000: clock cycles per Morse time unit (one dot length).
- CNT_WIDTH, 24: width of the duration counter. Must satisfy 2^CNT_WIDTH-1 >= 5*UNIT_CYCLES.
- MAX_ELEMS, 6: maximum elements per symbol.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- key_in  in  1  raw key level; 1 = key down (mark). Asynchronous to clk.
- char_out  out  8  decoded ASCII character.
- char_valid  out  1  char_out holds an unconsumed character.
- char_ready  in  1  sink accepts char_out this cycle.
- overflow  out  1  sticky: a character was dropped because the output register was full.
- sym_err  out  1  one-cycle pulse when an unknown or over-length symbol is emitted as '?'.

Behaviour:
- Reset: char_out=0x00, char_valid=0, overflow=0, sym_err=0. State=IDLE. Pattern and length cleared. Synchronizer flops=0.
- Reset asserted mid-symbol discards the partial symbol; nothing is emitted.
- Input path: key_in passes through a 2-flop synchronizer giving key_s. All timing uses key_s.
- Duration counter cnt:
  - Loads 1 on any cycle where key_s differs from its previous value.
  - Otherwise increments each cycle, saturating at all-ones.
- States:
  - IDLE: no pending elements. key_s rises -> MARK.
  - MARK: key_s falls -> classify the mark and go to GAP. cnt < 2*UNIT_CYCLES -> dot (0); otherwise -> dash (1).
    - Shift: pattern <= {pattern[MAX_ELEMS-2:0], bit}; len <= len+1.
    - If len is already MAX_ELEMS, set the internal too_long flag; pattern and len are unchanged.
  - GAP: key_s rises before cnt reaches 2*UNIT_CYCLES -> MARK (intra-character gap). When cnt == 2*UNIT_CYCLES -> emit character, clear pattern/len/too_long, go to WORD_WAIT.
  - WORD_WAIT: key_s rises -> MARK. When cnt == 5*UNIT_CYCLES -> emit word space (see Optional Feature), go to IDLE. cnt is not reset at character emission.
- Decode (combinational on len+pattern; first element is MSB of the len-bit field):
  - A-Z -> 0x41-0x5A, uppercase only. Examples: E=len1 0; T=len1 1; A=len2 01; S=len3 000; O=len3 111; Q=len4 1101.
  - 0-9 -> 0x30-0x39. Examples: 0=len5 11111; 5=len5 00000.
  - Any other pattern, or too_long set -> 0x3F '?' and a sym_err pulse in the same cycle char_valid rises.
- Output register:
  - Emission loads char_out and sets char_valid on the next clock edge, if !char_valid or char_ready is high that cycle (simultaneous consume+load is allowed).
  - If char_valid && !char_ready at emission, the new character is dropped and overflow is set. overflow clears only on rst.
  - char_valid clears on char_valid && char_ready with no simultaneous load.
  - char_out is stable while char_valid && !char_ready.
- Latency: char_valid rises 2*UNIT_CYCLES+1 cycles after the first cycle key_s is low following the last mark.

Optional Feature:
- Macro: MORSE_DEC_WORD_SPACE_EN.
- Defined: reaching 5*UNIT_CYCLES in WORD_WAIT emits 0x20 through the output register. Same full/overflow rules apply as for characters; sym_err is not pulsed.
- Undefined: WORD_WAIT still times out to IDLE but nothing is emitted. No space logic is synthesized.

Test Plan (UNIT_CYCLES=4, CNT_WIDTH=8, char_ready=1 unless noted):
- Reset: assert rst during a mark after key down 3 cycles, hold 2 cycles, release, key up 40 cycles -> char_valid stays 0, overflow=0, sym_err=0.
- Letter A: mark 4 cycles, gap 4, mark 12, then idle -> one char_valid pulse with char_out=0x41, sym_err=0, exactly 9 cycles after key_s falls.
- Digits: send 5 then 0 (all dots, then all dashes; 4-cycle intra-element gaps, 12-cycle inter-char gap) -> 0x35 followed by 0x30, no word space between them.
- Word gap with MORSE_DEC_WORD_SPACE_EN: E, 24-cycle gap, T -> 0x45, 0x20, 0x54. Without the macro -> 0x45, 0x54 only.
- Error: seven dots, or pattern ..-- (len4 0011) -> char_out=0x3F with a sym_err pulse coincident with char_valid rising.
- Backpressure: char_ready=0, send E then T -> char_out holds 0x45, overflow goes 1 when T is emitted. Raise char_ready -> 0x45 consumed, char_valid falls, overflow remains 1.
